// File: rtl/unsigned_down_async_reset_decumulator_if.sv
// Load/subtrahend bus of the down-accumulator, with its status returned to the source.
// The master drives LOAD/L/D/D_VALID. The slave (accumulator) returns D_READY and the status.
interface unsigned_down_async_reset_decumulator_if #(
  parameter int WIDTH = 4
) ();
  logic             LOAD;
  logic [WIDTH-1:0] L;
  logic [WIDTH-1:0] D;
  logic             D_VALID;
  logic             D_READY;
  logic [WIDTH-1:0] Q;
  logic             BORROW;
  logic             ZERO;
  logic             BUSY;

  modport master (
    output LOAD, L, D, D_VALID,
    input  D_READY, Q, BORROW, ZERO, BUSY
  );

  modport slave (
    input  LOAD, L, D, D_VALID,
    output D_READY, Q, BORROW, ZERO, BUSY
  );
endinterface

// File: rtl/unsigned_down_async_reset_decumulator.sv
// Down-accumulator: loads L, then subtracts each accepted D; Q updates on the accepting edge.
// D_READY is high only in RUN without LOAD; unaccepted D must be held by the source.
module unsigned_down_async_reset_decumulator #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic C,
  input  logic CLR_N,
  unsigned_down_async_reset_decumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    EMPTY = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic             borrow, borrow_nxt;
  logic [WIDTH:0]   diff;
  logic             d_ready;
  logic             xfer;

  // The extra top bit of the difference is the underflow borrow.
  assign diff    = {1'b0, q} - {1'b0, bus.D};
  assign d_ready = (state == RUN) && !bus.LOAD;
  assign xfer    = bus.D_VALID && d_ready;

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      state  <= IDLE;
      q      <= '0;
      borrow <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      borrow <= borrow_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    borrow_nxt = borrow;
    if (bus.LOAD) begin
      q_nxt      = bus.L;
      borrow_nxt = 1'b0;
      state_nxt  = (bus.L != '0) ? RUN : EMPTY;
    end else if (xfer) begin
      if (diff[WIDTH]) begin
        borrow_nxt = 1'b1;
        q_nxt      = SATURATE ? '0 : diff[WIDTH-1:0];
      end else begin
        q_nxt      = diff[WIDTH-1:0];
      end
      // A wrap that lands on a nonzero value keeps draining.
      state_nxt = (q_nxt == '0) ? EMPTY : RUN;
    end
  end

  assign bus.D_READY = d_ready;
  assign bus.Q       = q;
  assign bus.BORROW  = borrow;
  assign bus.ZERO    = (q == '0);
  assign bus.BUSY    = (state == RUN);

endmodule

// File: tb/tb_unsigned_down_async_reset_decumulator.sv
// Directed bench: wrapping (b0) and saturating (b1) instances share one stimulus stream.
module tb_unsigned_down_async_reset_decumulator;
  logic C;
  logic CLR_N;
  int   total;
  int   bad;

  unsigned_down_async_reset_decumulator_if #(.WIDTH(4)) b0 ();
  unsigned_down_async_reset_decumulator_if #(.WIDTH(4)) b1 ();

  unsigned_down_async_reset_decumulator #(.WIDTH(4), .SATURATE(1'b0)) dut0 (
    .C(C), .CLR_N(CLR_N), .bus(b0)
  );
  unsigned_down_async_reset_decumulator #(.WIDTH(4), .SATURATE(1'b1)) dut1 (
    .C(C), .CLR_N(CLR_N), .bus(b1)
  );

  initial begin
    C = 1'b0;
    forever #5 C = ~C;
  end

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge C);
    #1;
  endtask

  task automatic drive(input logic load, input logic [3:0] l, input logic [3:0] d, input logic dv);
    b0.LOAD = load; b0.L = l; b0.D = d; b0.D_VALID = dv;
    b1.LOAD = load; b1.L = l; b1.D = d; b1.D_VALID = dv;
    #1;
  endtask

  task automatic test_reset();
    CLR_N = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    #2;
    total++; if (b0.Q !== 4'd0) begin bad++; $display("FAIL reset_q act=%0d exp=0", b0.Q); end
    total++; if (b0.ZERO !== 1'b1) begin bad++; $display("FAIL reset_zero act=%b exp=1", b0.ZERO); end
    total++; if (b0.D_READY !== 1'b0) begin bad++; $display("FAIL reset_rdy act=%b exp=0", b0.D_READY); end
    total++; if (b0.BUSY !== 1'b0 || b1.BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy act=%b%b exp=00", b0.BUSY, b1.BUSY); end
    total++; if (b0.BORROW !== 1'b0) begin bad++; $display("FAIL reset_borrow act=%b exp=0", b0.BORROW); end
    @(negedge C);
    CLR_N = 1'b1;
    tick();
    // Load 5, then pulse reset between edges.
    drive(1'b1, 4'd5, 4'd0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    total++; if (b0.Q !== 4'd5) begin bad++; $display("FAIL pre_pulse_q act=%0d exp=5", b0.Q); end
    CLR_N = 1'b0;
    #1;
    total++; if (b0.Q !== 4'd0) begin bad++; $display("FAIL pulse_q act=%0d exp=0", b0.Q); end
    total++; if (b0.ZERO !== 1'b1) begin bad++; $display("FAIL pulse_zero act=%b exp=1", b0.ZERO); end
    total++; if (b0.D_READY !== 1'b0) begin bad++; $display("FAIL pulse_rdy act=%b exp=0", b0.D_READY); end
    #1;
    CLR_N = 1'b1;
    tick();
  endtask

  task automatic test_load_sub();
    drive(1'b1, 4'd9, 4'd0, 1'b0);
    tick();
    total++; if (b0.Q !== 4'd9) begin bad++; $display("FAIL load9_q act=%0d exp=9", b0.Q); end
    total++; if (b0.BUSY !== 1'b1) begin bad++; $display("FAIL load9_busy act=%b exp=1", b0.BUSY); end
    drive(1'b0, 4'd0, 4'd3, 1'b1);
    total++; if (b0.D_READY !== 1'b1) begin bad++; $display("FAIL run_rdy act=%b exp=1", b0.D_READY); end
    tick();
    total++; if (b0.Q !== 4'd6) begin bad++; $display("FAIL sub3_q act=%0d exp=6", b0.Q); end
    drive(1'b0, 4'd0, 4'd2, 1'b1);
    tick();
    total++; if (b0.Q !== 4'd4 || b1.Q !== 4'd4) begin bad++; $display("FAIL sub2_q act=%0d/%0d exp=4", b0.Q, b1.Q); end
    total++; if (b0.BUSY !== 1'b1) begin bad++; $display("FAIL sub2_busy act=%b exp=1", b0.BUSY); end
    total++; if (b0.BORROW !== 1'b0) begin bad++; $display("FAIL sub2_borrow act=%b exp=0", b0.BORROW); end
  endtask

  task automatic test_empty();
    drive(1'b0, 4'd0, 4'd4, 1'b1);
    tick();
    total++; if (b0.Q !== 4'd0) begin bad++; $display("FAIL empty_q act=%0d exp=0", b0.Q); end
    total++; if (b0.ZERO !== 1'b1) begin bad++; $display("FAIL empty_zero act=%b exp=1", b0.ZERO); end
    total++; if (b0.D_READY !== 1'b0 || b0.BUSY !== 1'b0) begin bad++; $display("FAIL empty_state rdy=%b busy=%b exp=0/0", b0.D_READY, b0.BUSY); end
    total++; if (b0.BORROW !== 1'b0) begin bad++; $display("FAIL empty_borrow act=%b exp=0", b0.BORROW); end
    drive(1'b0, 4'd0, 4'd1, 1'b1);
    tick();
    total++; if (b0.Q !== 4'd0 || b0.BORROW !== 1'b0) begin bad++; $display("FAIL empty_ignore q=%0d borrow=%b exp=0/0", b0.Q, b0.BORROW); end
  endtask

  task automatic test_underflow();
    drive(1'b1, 4'd3, 4'd0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd5, 1'b1);
    tick();
    total++; if (b0.Q !== 4'd14) begin bad++; $display("FAIL wrap_q act=%0d exp=14", b0.Q); end
    total++; if (b0.BORROW !== 1'b1 || b0.BUSY !== 1'b1) begin bad++; $display("FAIL wrap_flags borrow=%b busy=%b exp=1/1", b0.BORROW, b0.BUSY); end
    total++; if (b1.Q !== 4'd0) begin bad++; $display("FAIL sat_q act=%0d exp=0", b1.Q); end
    total++; if (b1.BORROW !== 1'b1 || b1.BUSY !== 1'b0) begin bad++; $display("FAIL sat_flags borrow=%b busy=%b exp=1/0", b1.BORROW, b1.BUSY); end
    drive(1'b1, 4'd2, 4'd0, 1'b0);
    tick();
    total++; if (b0.BORROW !== 1'b0 || b1.BORROW !== 1'b0) begin bad++; $display("FAIL borrow_clr act=%b/%b exp=0/0", b0.BORROW, b1.BORROW); end
    total++; if (b0.Q !== 4'd2 || b1.Q !== 4'd2) begin bad++; $display("FAIL reload_q act=%0d/%0d exp=2", b0.Q, b1.Q); end
  endtask

  task automatic test_load_priority();
    drive(1'b1, 4'd7, 4'd2, 1'b1);
    total++; if (b0.D_READY !== 1'b0) begin bad++; $display("FAIL prio_rdy act=%b exp=0", b0.D_READY); end
    tick();
    total++; if (b0.Q !== 4'd7) begin bad++; $display("FAIL prio_q act=%0d exp=7", b0.Q); end
    drive(1'b0, 4'd0, 4'd2, 1'b1);
    tick();
    total++; if (b0.Q !== 4'd5) begin bad++; $display("FAIL after_prio_q act=%0d exp=5", b0.Q); end
  endtask

  task automatic test_hold_and_zero();
    drive(1'b0, 4'd0, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (b0.Q !== 4'd5) begin bad++; $display("FAIL hold_q cyc=%0d act=%0d exp=5", i, b0.Q); end
    end
    drive(1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    total++; if (b0.Q !== 4'd5 || b0.BUSY !== 1'b1) begin bad++; $display("FAIL d0_xfer q=%0d busy=%b exp=5/1", b0.Q, b0.BUSY); end
    drive(1'b1, 4'd0, 4'd0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd0, 1'b0);
    total++; if (b0.Q !== 4'd0 || b0.ZERO !== 1'b1) begin bad++; $display("FAIL load0_q q=%0d zero=%b exp=0/1", b0.Q, b0.ZERO); end
    total++; if (b0.BUSY !== 1'b0 || b0.D_READY !== 1'b0) begin bad++; $display("FAIL load0_state busy=%b rdy=%b exp=0/0", b0.BUSY, b0.D_READY); end
  endtask

  task automatic test_reset_midop();
    drive(1'b1, 4'd6, 4'd0, 1'b0);
    tick();
    drive(1'b0, 4'd0, 4'd1, 1'b1);
    CLR_N = 1'b0;
    tick();
    total++; if (b0.Q !== 4'd0 || b0.BUSY !== 1'b0) begin bad++; $display("FAIL midop_q q=%0d busy=%b exp=0/0", b0.Q, b0.BUSY); end
    @(negedge C);
    CLR_N = 1'b1;
    tick();
    total++; if (b0.Q !== 4'd0 || b0.BUSY !== 1'b0 || b0.D_READY !== 1'b0) begin bad++; $display("FAIL post_rst_idle q=%0d busy=%b rdy=%b exp=0/0/0", b0.Q, b0.BUSY, b0.D_READY); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_sub();
    test_empty();
    test_underflow();
    test_load_priority();
    test_hold_and_zero();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
